// File: rtl/rc_pulse_gen_if.sv
// Command write channel and report read channel of rc_pulse_gen.
// The slave modport is the generator; the master modport is the host side.
interface rc_pulse_gen_if;
  logic [23:0] in_data;
  logic        in_wr;
  logic [3:0]  out_ctrl;
  logic [23:0] out_data;
  logic        out_wr;
  logic        out_wr_rdy;

  modport master (
    output in_data, in_wr, out_wr_rdy,
    input  out_ctrl, out_data, out_wr
  );

  modport slave (
    input  in_data, in_wr, out_wr_rdy,
    output out_ctrl, out_data, out_wr
  );
endinterface

// File: rtl/rc_pulse_gen.sv
// Six-channel servo PWM generator with double-buffered microsecond widths
// and an optional per-frame status report.
module rc_pulse_gen #(
  parameter int unsigned CLK_MHZ    = 50,
  parameter int unsigned FRAME_US   = 20000,
  parameter int unsigned LEN        = 17,
  parameter int unsigned DEFAULT_US = 1500
) (
  input  logic          clk,
  input  logic          reset,
  rc_pulse_gen_if.slave bus_io,
  output logic [5:0]    rc_out
);

  localparam int unsigned NumCh = 6;
  localparam int unsigned PW    = (CLK_MHZ > 1) ? $clog2(CLK_MHZ) : 1;
  // Wide enough to hold FRAME_US itself, so fcnt+1 never overflows.
  localparam int unsigned FW    = $clog2(FRAME_US + 1);

  localparam logic [PW-1:0] PrescMax = PW'(CLK_MHZ - 1);
  localparam logic [FW-1:0] FrameMax = FW'(FRAME_US - 1);

  logic [PW-1:0]  presc_q, presc_d;
  logic [FW-1:0]  fcnt_q, fcnt_d;
  logic [LEN-1:0] shadow_q [NumCh];
  logic [LEN-1:0] shadow_d [NumCh];
  logic [FW-1:0]  active_q [NumCh];
  logic [FW-1:0]  active_d [NumCh];
  logic [FW-1:0]  clamped  [NumCh];
  logic [5:0]     enable_q, enable_d;
  logic           notify_q, notify_d;
  logic [5:0]     rc_q, rc_d;
  logic           out_wr_q, out_wr_d;
  logic [23:0]    out_data_q, out_data_d;
  logic [15:0]    seq_q, seq_d;
  logic           ovr_q, ovr_d;

  logic       tick;
  logic       frame_start;
  logic [3:0] cmd_code;
  logic       unused_in_data;

  assign cmd_code       = bus_io.in_data[23:20];
  assign unused_in_data = ^bus_io.in_data[19:LEN];

  assign tick        = (presc_q == PrescMax);
  assign frame_start = tick && (fcnt_q == FrameMax);

  always_comb begin
    presc_d = tick ? '0 : presc_q + PW'(1);
    fcnt_d  = fcnt_q;
    if (frame_start) begin
      fcnt_d = '0;
    end else if (tick) begin
      fcnt_d = fcnt_q + FW'(1);
    end
  end

  always_comb begin
    shadow_d = shadow_q;
    enable_d = enable_q;
    notify_d = notify_q;
    if (bus_io.in_wr) begin
      if (cmd_code == 4'hF) begin
        enable_d = bus_io.in_data[5:0];
        notify_d = bus_io.in_data[6];
      end else if (cmd_code < 4'(NumCh)) begin
        shadow_d[cmd_code[2:0]] = bus_io.in_data[LEN-1:0];
      end
    end
  end

  // Frames latch the registered shadow, so a write coincident with frame_start waits a frame.
  always_comb begin
    active_d = active_q;
    rc_d     = rc_q;
    for (int i = 0; i < NumCh; i++) begin
      clamped[i] = (32'(shadow_q[i]) >= FRAME_US) ? FrameMax : FW'(shadow_q[i]);
      if (frame_start) begin
        active_d[i] = clamped[i];
        rc_d[i]     = enable_q[i] && (clamped[i] != '0);
      end else if (tick && ((fcnt_q + FW'(1)) == active_q[i])) begin
        rc_d[i] = 1'b0;
      end
    end
    rc_d = rc_d & enable_d;
  end

  // The overrun flag moves into the payload when a report is issued, so an overrun
  // occurring while that report waits is kept for the following one.
  always_comb begin
    out_wr_d   = out_wr_q & ~bus_io.out_wr_rdy;
    out_data_d = out_data_q;
    seq_d      = seq_q;
    ovr_d      = ovr_q;
    if (frame_start) begin
      seq_d = seq_q + 16'd1;
      if (out_wr_q) begin
        ovr_d = 1'b1;
      end else if (notify_q) begin
        out_wr_d   = 1'b1;
        out_data_d = {ovr_q, 7'b0, seq_q};
        ovr_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      fcnt_q     <= '0;
      enable_q   <= '0;
      notify_q   <= 1'b0;
      rc_q       <= '0;
      out_wr_q   <= 1'b0;
      out_data_q <= '0;
      seq_q      <= '0;
      ovr_q      <= 1'b0;
      for (int i = 0; i < NumCh; i++) begin
        shadow_q[i] <= LEN'(DEFAULT_US);
        active_q[i] <= '0;
      end
    end else begin
      presc_q    <= presc_d;
      fcnt_q     <= fcnt_d;
      enable_q   <= enable_d;
      notify_q   <= notify_d;
      rc_q       <= rc_d;
      out_wr_q   <= out_wr_d;
      out_data_q <= out_data_d;
      seq_q      <= seq_d;
      ovr_q      <= ovr_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  assign rc_out          = rc_q;
  assign bus_io.out_wr   = out_wr_q;
  assign bus_io.out_data = out_data_q;
  assign bus_io.out_ctrl = out_wr_q ? 4'h8 : 4'h0;

endmodule

// File: tb/tb_rc_pulse_gen.sv
// Bench for rc_pulse_gen: directed scenarios then random commands, every cycle
// compared against a frame-timing reference model.
module tb_rc_pulse_gen;

  localparam int unsigned ClkMhz    = 2;
  localparam int unsigned FrameUs   = 100;
  localparam int unsigned Len       = 17;
  localparam int unsigned DefaultUs = 15;
  localparam int unsigned Per       = ClkMhz * FrameUs;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] rc_out;

  rc_pulse_gen_if bus ();

  rc_pulse_gen #(
    .CLK_MHZ   (ClkMhz),
    .FRAME_US  (FrameUs),
    .LEN       (Len),
    .DEFAULT_US(DefaultUs)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus),
    .rc_out(rc_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: time since the last frame start decides every pulse.
  int unsigned m_shadow [6];
  int unsigned m_width  [6];
  logic [5:0]  m_en, m_alive;
  logic        m_notify, m_pend, m_ovr;
  logic [23:0] m_data;
  logic [15:0] m_seq;
  int unsigned m_cnt, m_since;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic wr, input logic [23:0] d,
                            input logic rdy);
    logic        fs;
    logic [5:0]  old_en;
    logic        old_notify, old_pend;
    int unsigned old_shadow [6];
    int          idx;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        m_shadow[i] = DefaultUs;
        m_width[i]  = 0;
      end
      m_en = '0; m_alive = '0; m_notify = 1'b0; m_pend = 1'b0; m_ovr = 1'b0;
      m_data = '0; m_seq = '0; m_cnt = 0; m_since = 32'hFFFF_0000;
      return;
    end
    fs         = (m_cnt % Per) == (Per - 1);
    old_en     = m_en;
    old_notify = m_notify;
    old_pend   = m_pend;
    old_shadow = m_shadow;
    if (m_pend && rdy) m_pend = 1'b0;
    if (fs) begin
      if (old_pend) begin
        m_ovr = 1'b1;
      end else if (old_notify) begin
        m_pend = 1'b1;
        m_data = {m_ovr, 7'b0, m_seq};
        m_ovr  = 1'b0;
      end
      m_seq = m_seq + 16'd1;
    end
    if (wr) begin
      idx = int'(d[23:20]);
      if (idx == 15) begin
        m_en     = d[5:0];
        m_notify = d[6];
      end else if (idx < 6) begin
        m_shadow[idx] = 32'(d[Len-1:0]);
      end
    end
    if (fs) begin
      m_since = 0;
      for (int i = 0; i < 6; i++) begin
        m_width[i] = (old_shadow[i] >= FrameUs) ? FrameUs - 1 : old_shadow[i];
        m_alive[i] = old_en[i] && (m_width[i] != 0);
      end
    end else begin
      m_since++;
    end
    m_alive = m_alive & m_en;
    m_cnt++;
  endtask

  function automatic logic [5:0] exp_rc();
    logic [5:0] r;
    for (int i = 0; i < 6; i++) r[i] = m_alive[i] && (m_since < ClkMhz * m_width[i]);
    return r;
  endfunction

  task automatic step(input logic rst, input logic wr, input logic [23:0] d, input logic rdy);
    reset          = rst;
    bus.in_wr      = wr;
    bus.in_data    = d;
    bus.out_wr_rdy = rdy;
    @(posedge clk);
    model_edge(rst, wr, d, rdy);
    #1;
    check_eq("rc_out", 32'(rc_out), 32'(exp_rc()));
    check_eq("out_wr", 32'(bus.out_wr), 32'(m_pend));
    check_eq("out_ctrl", 32'(bus.out_ctrl), m_pend ? 32'h8 : 32'h0);
    if (m_pend) check_eq("out_data", 32'(bus.out_data), 32'(m_data));
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, 24'h0, rdy);
  endtask

  // Stops with the next clock edge being a frame start.
  task automatic run_to_fs(input logic rdy);
    while ((m_cnt % Per) != (Per - 1)) step(1'b0, 1'b0, 24'h0, rdy);
  endtask

  task automatic wr_cmd(input logic [3:0] code, input logic [19:0] val, input logic rdy);
    step(1'b0, 1'b1, {code, val}, rdy);
  endtask

  task automatic random_phase(input int n);
    logic [23:0] d;
    logic        wr;
    int unsigned sel;
    for (int k = 0; k < n; k++) begin
      d   = 24'($urandom);
      wr  = ($urandom_range(0, 39) == 0);
      sel = $urandom_range(0, 9);
      if (sel < 6) begin
        d[23:20]    = 4'(sel);
        d[Len-1:0]  = 17'($urandom_range(0, 260));
      end else if (sel < 9) begin
        d[23:20] = 4'hF;
      end
      step(1'b0, wr, d, $urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_wr      = 1'b0;
    bus.in_data    = '0;
    bus.out_wr_rdy = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 24'h0, 1'b0);
    check_eq("rst_rc_out", 32'(rc_out), 32'h0);
    check_eq("rst_out_data", 32'(bus.out_data), 32'h0);
    check_eq("rst_out_wr", 32'(bus.out_wr), 32'h0);

    // All channels at default width.
    wr_cmd(4'hF, 20'h0003F, 1'b0);
    run(2 * Per, 1'b0);

    // ch2 update mid-pulse, then coincident with frame start.
    run_to_fs(1'b0);
    run(20, 1'b0);
    wr_cmd(4'd2, 20'd40, 1'b0);
    run(2 * Per, 1'b0);
    run_to_fs(1'b0);
    wr_cmd(4'd2, 20'd60, 1'b0);
    run(2 * Per, 1'b0);

    // ch0 width 0 and clamped width 250.
    wr_cmd(4'd0, 20'd0, 1'b0);
    run(2 * Per, 1'b0);
    wr_cmd(4'd0, 20'd250, 1'b0);
    run(2 * Per, 1'b0);

    // ch1 disabled mid-pulse, re-enabled mid-frame.
    run_to_fs(1'b0);
    run(10, 1'b0);
    wr_cmd(4'hF, 20'h0003D, 1'b0);
    run(20, 1'b0);
    wr_cmd(4'hF, 20'h0003F, 1'b0);
    run(2 * Per, 1'b0);

    // Reports stalled for three frames, then accepted.
    wr_cmd(4'hF, 20'h0007F, 1'b0);
    run_to_fs(1'b0);
    run(3 * Per, 1'b0);
    run(3 * Per, 1'b1);

    // Reset mid-pulse with a report pending.
    run_to_fs(1'b0);
    run(10, 1'b0);
    step(1'b1, 1'b0, 24'h0, 1'b0);
    check_eq("rst_mid_rc", 32'(rc_out), 32'h0);
    check_eq("rst_mid_wr", 32'(bus.out_wr), 32'h0);
    run(Per + Per / 2, 1'b1);

    wr_cmd(4'hF, 20'h0003F, 1'b1);
    random_phase(4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
